// File: rtl/cordic_request_arbiter.sv
// cordic_request_arbiter: round-robin sharing of one pipelined CORDIC core with tagged result routing; CORDIC_ARB_STATS_EN adds grant counters
module cordic_request_arbiter #(
  parameter int N_REQ   = 4,
  parameter int BITS    = 33,
  parameter int LATENCY = 17
)(
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [N_REQ-1:0]      i_req_valid,
  input  logic [N_REQ*BITS-1:0] i_req_x,
  input  logic [N_REQ*BITS-1:0] i_req_y,
  input  logic [N_REQ*BITS-1:0] i_req_z,
  input  logic [N_REQ*2-1:0]    i_req_mode,
  input  logic [N_REQ-1:0]      i_req_rot_en,
  output logic [N_REQ-1:0]      o_req_ready,
  input  logic                  i_pause,
  output logic                  o_idle,
  output logic                  o_cordic_ready,
  output logic [BITS-1:0]       o_cordic_x,
  output logic [BITS-1:0]       o_cordic_y,
  output logic [BITS-1:0]       o_cordic_z,
  output logic [1:0]            o_cordic_mode,
  output logic                  o_cordic_rot_en,
  input  logic                  i_cordic_valid,
  input  logic [BITS-1:0]       i_cordic_x,
  input  logic [BITS-1:0]       i_cordic_y,
  input  logic [BITS-1:0]       i_cordic_z,
  output logic [N_REQ-1:0]      o_rsp_valid,
  output logic [BITS-1:0]       o_rsp_x,
  output logic [BITS-1:0]       o_rsp_y,
  output logic [BITS-1:0]       o_rsp_z,
  output logic                  o_err
`ifdef CORDIC_ARB_STATS_EN
  ,
  output logic [N_REQ*16-1:0]   o_grant_cnt
`endif
);
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int WW = $clog2(LATENCY + 1);
  typedef enum logic [1:0] {RUN, DRAIN, PAUSED} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d, gnt_id, cand, iss_id_q;
  logic gnt_any, run, tags_empty, tail_v, warm;
  logic [IW-1:0] tail_id;
  logic tag_v_q [LATENCY];
  logic [IW-1:0] tag_id_q [LATENCY];
  logic [WW-1:0] warm_q;
  int k;
  assign run = state_q == RUN && !i_pause && !i_rst;
  assign o_idle = state_q == PAUSED;
  assign tail_v = tag_v_q[LATENCY-1];
  assign tail_id = tag_id_q[LATENCY-1];
  assign warm = warm_q == WW'(LATENCY);
  // round-robin search starting at ptr; first pending requester wins
  always_comb begin
    o_req_ready = '0;
    gnt_any = 1'b0;
    gnt_id = '0;
    cand = '0;
    k = 0;
    for (int i = 0; i < N_REQ; i++) begin
      k = (int'(ptr_q) + i >= N_REQ) ? int'(ptr_q) + i - N_REQ : int'(ptr_q) + i;
      cand = IW'(k);
      if (!gnt_any && run && i_req_valid[cand]) begin
        gnt_any = 1'b1;
        gnt_id = cand;
      end
    end
    if (gnt_any) o_req_ready[gnt_id] = 1'b1;
    ptr_d = !gnt_any ? ptr_q : (gnt_id == IW'(N_REQ - 1)) ? '0 : gnt_id + 1'b1;
  end
  // pipeline is empty when nothing is being issued and no tag is in flight
  always_comb begin
    tags_empty = !o_cordic_ready;
    for (int i = 0; i < LATENCY; i++) tags_empty = tags_empty & !tag_v_q[i];
  end
  // run/drain/paused sequencing; releasing pause always returns to RUN
  always_comb begin
    state_d = state_q == RUN   ? (i_pause ? DRAIN : RUN) :
              state_q == DRAIN ? (!i_pause ? RUN : tags_empty ? PAUSED : DRAIN) :
                                 (i_pause ? PAUSED : RUN);
  end
  // issue register, tag shift pipeline, response routing and error flag
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= RUN;
      ptr_q <= '0;
      iss_id_q <= '0;
      o_cordic_ready <= 1'b0;
      o_cordic_x <= '0;
      o_cordic_y <= '0;
      o_cordic_z <= '0;
      o_cordic_mode <= '0;
      o_cordic_rot_en <= 1'b0;
      o_rsp_valid <= '0;
      o_rsp_x <= '0;
      o_rsp_y <= '0;
      o_rsp_z <= '0;
      o_err <= 1'b0;
      warm_q <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        tag_v_q[i] <= 1'b0;
        tag_id_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      o_cordic_ready <= gnt_any;
      if (gnt_any) begin
        iss_id_q <= gnt_id;
        o_cordic_x <= i_req_x[gnt_id*BITS +: BITS];
        o_cordic_y <= i_req_y[gnt_id*BITS +: BITS];
        o_cordic_z <= i_req_z[gnt_id*BITS +: BITS];
        o_cordic_mode <= i_req_mode[gnt_id*2 +: 2];
        o_cordic_rot_en <= i_req_rot_en[gnt_id];
      end
      tag_v_q[0] <= o_cordic_ready;
      tag_id_q[0] <= iss_id_q;
      for (int i = 1; i < LATENCY; i++) begin
        tag_v_q[i] <= tag_v_q[i-1];
        tag_id_q[i] <= tag_id_q[i-1];
      end
      warm_q <= warm ? warm_q : warm_q + 1'b1;
      o_rsp_valid <= '0;
      if (tail_v && i_cordic_valid) begin
        o_rsp_valid[tail_id] <= 1'b1;
        o_rsp_x <= i_cordic_x;
        o_rsp_y <= i_cordic_y;
        o_rsp_z <= i_cordic_z;
      end
      if (warm && (tail_v ^ i_cordic_valid)) o_err <= 1'b1;
    end
  end
`ifdef CORDIC_ARB_STATS_EN
  logic [15:0] cnt_q [N_REQ];
  // saturating per-requester handshake counters
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < N_REQ; i++) cnt_q[i] <= '0;
    end else if (gnt_any && cnt_q[gnt_id] != 16'hFFFF) begin
      cnt_q[gnt_id] <= cnt_q[gnt_id] + 16'd1;
    end
  end
  for (genvar g = 0; g < N_REQ; g++) begin : g_cnt
    assign o_grant_cnt[g*16 +: 16] = cnt_q[g];
  end
`endif
endmodule

// File: tb/tb_cordic_request_arbiter.sv
// tb_cordic_request_arbiter: directed self-checking bench with a pass-through CORDIC model
module tb_cordic_request_arbiter;
  localparam int N = 4;
  localparam int B = 33;
  localparam int L = 17;
  logic clk, rst, pause, inj;
  logic [N-1:0] valid, ready, rsp_valid, rot_en;
  logic [N*B-1:0] req_x, req_y, req_z;
  logic [N*2-1:0] req_mode;
  logic idle, c_ready, c_rot_en, c_valid, err;
  logic [B-1:0] c_x, c_y, c_z, r_x, r_y, r_z, o_x, o_y, o_z;
  logic [1:0] c_mode;
  logic mv [L];
  logic [B-1:0] mx [L], my [L], mz [L];
  int n_pass, n_total;
`ifdef CORDIC_ARB_STATS_EN
  logic [N*16-1:0] gcnt;
`endif

  cordic_request_arbiter #(.N_REQ(N), .BITS(B), .LATENCY(L)) dut (
    .i_clk(clk), .i_rst(rst), .i_req_valid(valid),
    .i_req_x(req_x), .i_req_y(req_y), .i_req_z(req_z),
    .i_req_mode(req_mode), .i_req_rot_en(rot_en), .o_req_ready(ready),
    .i_pause(pause), .o_idle(idle), .o_cordic_ready(c_ready),
    .o_cordic_x(o_x), .o_cordic_y(o_y), .o_cordic_z(o_z),
    .o_cordic_mode(c_mode), .o_cordic_rot_en(c_rot_en),
    .i_cordic_valid(c_valid), .i_cordic_x(c_x), .i_cordic_y(c_y), .i_cordic_z(c_z),
    .o_rsp_valid(rsp_valid), .o_rsp_x(r_x), .o_rsp_y(r_y), .o_rsp_z(r_z),
    .o_err(err)
`ifdef CORDIC_ARB_STATS_EN
    , .o_grant_cnt(gcnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // model core: L-cycle pipe, x and z pass through, y returned incremented
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < L; i++) mv[i] <= 1'b0;
    end else begin
      mv[0] <= c_ready;
      mx[0] <= o_x;
      my[0] <= o_y + 1'b1;
      mz[0] <= o_z;
      for (int i = 1; i < L; i++) begin
        mv[i] <= mv[i-1];
        mx[i] <= mx[i-1];
        my[i] <= my[i-1];
        mz[i] <= mz[i-1];
      end
    end
  end
  assign c_valid = mv[L-1] | inj;
  assign c_x = mx[L-1];
  assign c_y = my[L-1];
  assign c_z = mz[L-1];

  function automatic logic [B-1:0] ex(int k); return B'(100 + k); endfunction
  function automatic logic [B-1:0] ey(int k); return B'(201 + k); endfunction
  function automatic logic [B-1:0] ez(int k); return (k == 2) ? 33'h031EB851E : B'(300 + k); endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; pause = 1'b0; inj = 1'b0; valid = '0;
    repeat (3) tick;
    valid = 4'b1111;
    #1;
    n_total++; if (ready !== 4'b0000) $display("FAIL rst_ready got %b exp 0000", ready); else n_pass++;
    n_total++; if (c_ready !== 1'b0) $display("FAIL rst_cordic_ready got %b exp 0", c_ready); else n_pass++;
    n_total++; if (o_z !== '0) $display("FAIL rst_cordic_z got %h exp 0", o_z); else n_pass++;
    n_total++; if (rsp_valid !== 4'b0000) $display("FAIL rst_rsp_valid got %b exp 0000", rsp_valid); else n_pass++;
    n_total++; if (idle !== 1'b0) $display("FAIL rst_idle got %b exp 0", idle); else n_pass++;
    n_total++; if (err !== 1'b0) $display("FAIL rst_err got %b exp 0", err); else n_pass++;
    rst = 1'b0;
    #1;
    n_total++; if (ready !== 4'b0001) $display("FAIL rst_first_grant got %b exp 0001", ready); else n_pass++;
  endtask

  task automatic test_round_robin;
    logic [N-1:0] eg, er;
    int k;
    for (int r = 0; r < 28; r++) begin
      if (r == 8) valid = '0;
      #1;
      eg = (r < 8) ? 4'b0001 << (r % 4) : 4'b0000;
      k = (r - 19) % 4;
      er = (r >= 19 && r <= 26) ? 4'b0001 << k : 4'b0000;
      n_total++; if (ready !== eg) $display("FAIL rr_grant c%0d got %b exp %b", r, ready, eg); else n_pass++;
      n_total++; if (rsp_valid !== er) $display("FAIL rr_rsp c%0d got %b exp %b", r, rsp_valid, er); else n_pass++;
      if (er != 0) begin
        n_total++;
        if (r_x !== ex(k) || r_y !== ey(k) || r_z !== ez(k))
          $display("FAIL rr_data c%0d got %h/%h/%h exp %h/%h/%h", r, r_x, r_y, r_z, ex(k), ey(k), ez(k));
        else n_pass++;
      end
      tick;
    end
  endtask

  task automatic test_sparse_wrap;
    logic [N-1:0] seq [4];
    logic [N-1:0] eg, er;
    seq[0] = 4'b0100; seq[1] = 4'b0001; seq[2] = 4'b0100; seq[3] = 4'b0001;
    for (int r = 0; r < 25; r++) begin
      valid = (r == 0) ? 4'b0100 : (r < 4) ? 4'b0101 : 4'b0000;
      #1;
      eg = (r < 4) ? seq[r] : 4'b0000;
      er = (r >= 19 && r <= 22) ? seq[r-19] : 4'b0000;
      n_total++; if (ready !== eg) $display("FAIL sparse_grant c%0d got %b exp %b", r, ready, eg); else n_pass++;
      n_total++; if (rsp_valid !== er) $display("FAIL sparse_rsp c%0d got %b exp %b", r, rsp_valid, er); else n_pass++;
      if (er == 4'b0100) begin
        n_total++; if (r_z !== 33'h031EB851E) $display("FAIL sparse_z2 c%0d got %h exp 031eb851e", r, r_z); else n_pass++;
      end
      if (er == 4'b0001) begin
        n_total++; if (r_z !== ez(0)) $display("FAIL sparse_z0 c%0d got %h exp %h", r, r_z, ez(0)); else n_pass++;
      end
      tick;
    end
  endtask

  task automatic test_pause;
    logic [N-1:0] eg, er;
    logic ei;
    valid = 4'b0010;
    for (int r = 0; r < 48; r++) begin
      if (r == 5) pause = 1'b1;
      if (r == 26) pause = 1'b0;
      if (r == 28) valid = '0;
      #1;
      eg = (r < 5 || r == 27) ? 4'b0010 : 4'b0000;
      er = ((r >= 19 && r <= 23) || r == 46) ? 4'b0010 : 4'b0000;
      ei = r >= 24 && r <= 26;
      n_total++; if (ready !== eg) $display("FAIL pause_grant c%0d got %b exp %b", r, ready, eg); else n_pass++;
      n_total++; if (rsp_valid !== er) $display("FAIL pause_rsp c%0d got %b exp %b", r, rsp_valid, er); else n_pass++;
      n_total++; if (idle !== ei) $display("FAIL pause_idle c%0d got %b exp %b", r, idle, ei); else n_pass++;
      if (er != 0) begin
        n_total++; if (r_y !== ey(1)) $display("FAIL pause_data c%0d got %h exp %h", r, r_y, ey(1)); else n_pass++;
      end
      tick;
    end
  endtask

  task automatic test_error;
    #1;
    n_total++; if (err !== 1'b0) $display("FAIL err_before got %b exp 0", err); else n_pass++;
    inj = 1'b1;
    tick;
    inj = 1'b0;
    #1;
    n_total++; if (rsp_valid !== 4'b0000) $display("FAIL err_no_rsp got %b exp 0000", rsp_valid); else n_pass++;
    n_total++; if (err !== 1'b1) $display("FAIL err_set got %b exp 1", err); else n_pass++;
    repeat (5) tick;
    n_total++; if (err !== 1'b1) $display("FAIL err_sticky got %b exp 1", err); else n_pass++;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    #1;
    n_total++; if (err !== 1'b0) $display("FAIL err_cleared got %b exp 0", err); else n_pass++;
  endtask

`ifdef CORDIC_ARB_STATS_EN
  task automatic test_stats;
    n_total++; if (gcnt !== '0) $display("FAIL stats_reset got %h exp 0", gcnt); else n_pass++;
    valid = 4'b0010;
    repeat (70000) tick;
    valid = '0;
    #1;
    n_total++; if (gcnt[31:16] !== 16'hFFFF) $display("FAIL stats_sat got %h exp ffff", gcnt[31:16]); else n_pass++;
    n_total++; if (gcnt[15:0] !== 16'h0 || gcnt[63:32] !== 32'h0) $display("FAIL stats_others got %h exp 0", gcnt); else n_pass++;
  endtask
`endif

  initial begin
    n_pass = 0;
    n_total = 0;
    for (int k = 0; k < N; k++) begin
      req_x[k*B +: B] = ex(k);
      req_y[k*B +: B] = ey(k) - 1'b1;
      req_z[k*B +: B] = ez(k);
      req_mode[k*2 +: 2] = 2'(k);
      rot_en[k] = k[0];
    end
    test_reset;
    test_round_robin;
    test_sparse_wrap;
    test_pause;
    test_error;
`ifdef CORDIC_ARB_STATS_EN
    test_stats;
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
